// File: rtl/mul_share_arb_pkg.sv
// Shared constants and types for the mul_share_arb slice.
//   LUT_LAT  : pipeline depth of mul_lut (registered operands to y)
//   OP_W     : signed operand width
//   PROD_W   : signed product width
//   tag_t    : per-pair tag {valid, last, id} travelling beside the multiplier
package mul_share_arb_pkg;

    localparam int LUT_LAT  = 5;
    localparam int OP_W     = 8;
    localparam int PROD_W   = 16;
    // Sized for the largest supported requester count (8).
    localparam int TAG_ID_W = 3;

    typedef struct packed {
        logic                valid;
        logic                last;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/mul_lut.sv
// Pipelined signed 8x8 multiplier with a fixed latency.
// Operands are captured on an edge; their product appears on y LAT edges later.
// Data registers carry no reset; consumers qualify y with their own valid tag.
//   clk : clock
//   a   : signed operand
//   b   : signed operand
//   y   : signed product, delayed by LAT cycles after operand capture
module mul_lut
    import mul_share_arb_pkg::*;
#(
    parameter int LAT = LUT_LAT
) (
    input  logic                     clk,
    input  logic signed [OP_W-1:0]   a,
    input  logic signed [OP_W-1:0]   b,
    output logic signed [PROD_W-1:0] y
);

    logic signed [OP_W-1:0]   a_r;
    logic signed [OP_W-1:0]   b_r;
    logic signed [PROD_W-1:0] pipe_r [LAT];

    // Operand capture and product delay line.
    always_ff @(posedge clk) begin
        a_r       <= a;
        b_r       <= b;
        pipe_r[0] <= PROD_W'(a_r) * PROD_W'(b_r);
        for (int i = 1; i < LAT; i++) begin
            pipe_r[i] <= pipe_r[i-1];
        end
    end

    assign y = pipe_r[LAT-1];

endmodule

// File: rtl/mul_share_arb_rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts at ptr+1 (mod NREQ); the first asserted request wins.
//   req   : request vector
//   ptr   : index of the most recent winner
//   grant : one-hot winner, zero when no request
//   idx   : encoded winner index (0 when no request)
//   any   : at least one request asserted
module mul_share_arb_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Rotating priority search beginning just past the last winner.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int off = 1; off <= NREQ; off++) begin
            if (!any && req[(int'(ptr) + off) % NREQ]) begin
                any                                = 1'b1;
                idx                                = IDX_W'((int'(ptr) + off) % NREQ);
                grant[(int'(ptr) + off) % NREQ]    = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/mul_share_arb.sv
// Shares one pipelined signed multiplier among NREQ requesters and forms
// per-requester dot-product sums, emitted when a pair marked last retires.
//   clk       : clock
//   rstn      : synchronous active-low reset
//   req_valid : per-requester operand valid
//   req_ready : per-requester grant (one-hot or zero)
//   req_w     : signed weights, requester i at [8i+7:8i]
//   req_x     : signed activations, same packing
//   req_last  : pair closes the requester's accumulation group
//   out_valid : one-cycle pulse, group sum valid
//   out_id    : requester owning out_sum
//   out_sum   : signed group sum (wraps at ACC_W)
//   busy      : any tag stage holds a valid pair
module mul_share_arb
    import mul_share_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ACC_W   = 32,
    parameter int MUL_LAT = LUT_LAT
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*OP_W-1:0]      req_w,
    input  logic [NREQ*OP_W-1:0]      req_x,
    input  logic [NREQ-1:0]           req_last,
    output logic                      out_valid,
    output logic [$clog2(NREQ)-1:0]   out_id,
    output logic signed [ACC_W-1:0]   out_sum,
    output logic                      busy
);

    localparam int IDX_W = $clog2(NREQ);

    logic [IDX_W-1:0]          rr_ptr_r;
    logic [NREQ-1:0]           grant_s;
    logic [IDX_W-1:0]          win_idx_s;
    logic                      win_any_s;
    logic signed [OP_W-1:0]    w_s;
    logic signed [OP_W-1:0]    x_s;
    logic signed [PROD_W-1:0]  y_s;
    // Stage 0 lines up with mul_lut operand capture, stage MUL_LAT with y.
    tag_t                      tag_r [MUL_LAT+1];
    tag_t                      ret_s;
    logic [IDX_W-1:0]          ret_id_s;
    logic signed [ACC_W-1:0]   p_s;
    logic signed [ACC_W-1:0]   sum_s;
    logic signed [ACC_W-1:0]   acc_r [NREQ];
    logic                      out_valid_r;
    logic [IDX_W-1:0]          out_id_r;
    logic signed [ACC_W-1:0]   out_sum_r;
    logic                      busy_s;

    mul_share_arb_rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_r),
        .grant (grant_s),
        .idx   (win_idx_s),
        .any   (win_any_s)
    );

    // A grant is always a transfer: grants only go to valid requesters.
    assign req_ready = grant_s;
    assign w_s       = req_w[int'(win_idx_s)*OP_W +: OP_W];
    assign x_s       = req_x[int'(win_idx_s)*OP_W +: OP_W];

    mul_lut #(
        .LAT (MUL_LAT)
    ) u_mul (
        .clk (clk),
        .a   (w_s),
        .b   (x_s),
        .y   (y_s)
    );

    // Round-robin pointer follows the most recent transfer.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr_r <= IDX_W'(NREQ - 1);
        end else if (win_any_s) begin
            rr_ptr_r <= win_idx_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Tag pipeline shifting in lock-step with the multiplier.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i <= MUL_LAT; i++) begin
                tag_r[i] <= '0;
            end
        end else begin
            tag_r[0].valid <= win_any_s;
            tag_r[0].last  <= req_last[win_idx_s];
            tag_r[0].id    <= TAG_ID_W'(win_idx_s);
            for (int i = 1; i <= MUL_LAT; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    // Busy reflects pairs in flight only, not open groups.
    always_comb begin
        busy_s = 1'b0;
        for (int i = 0; i <= MUL_LAT; i++) begin
            busy_s = busy_s | tag_r[i].valid;
        end
    end

    assign ret_s    = tag_r[MUL_LAT];
    assign ret_id_s = IDX_W'(ret_s.id);
    assign p_s      = {{(ACC_W-PROD_W){y_s[PROD_W-1]}}, y_s};
    assign sum_s    = acc_r[ret_id_s] + p_s;

    // Accumulate retiring products; a last pair emits the sum and clears its accumulator.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NREQ; i++) begin
                acc_r[i] <= '0;
            end
            out_valid_r <= 1'b0;
            out_id_r    <= '0;
            out_sum_r   <= '0;
        end else if (ret_s.valid) begin
            if (ret_s.last) begin
                out_sum_r        <= sum_s;
                out_id_r         <= ret_id_s;
                out_valid_r      <= 1'b1;
                acc_r[ret_id_s]  <= '0;
            end else begin
                acc_r[ret_id_s]  <= sum_s;
                out_valid_r      <= 1'b0;
            end
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid = out_valid_r;
    assign out_id    = out_id_r;
    assign out_sum   = out_sum_r;
    assign busy      = busy_s;

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb (NREQ=4, ACC_W=32, MUL_LAT=5).
// A per-cycle vector table covers single-requester groups, signed extremes
// and interleaved groups; hand sequences cover round-robin fairness,
// mid-operation reset and idle behaviour.
module tb_mul_share_arb;

    logic        clk;
    logic        rstn;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_w;
    logic [31:0] req_x;
    logic [3:0]  req_last;
    logic        out_valid;
    logic [1:0]  out_id;
    logic [31:0] out_sum;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    mul_share_arb #(
        .NREQ    (4),
        .ACC_W   (32),
        .MUL_LAT (5)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_w     (req_w),
        .req_x     (req_x),
        .req_last  (req_last),
        .out_valid (out_valid),
        .out_id    (out_id),
        .out_sum   (out_sum),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] w;
        logic [31:0] x;
        logic [3:0]  exp_ready;
        logic        exp_ov;
        logic [1:0]  exp_id;
        logic [31:0] exp_sum;
        logic        exp_busy;
    } vec_t;

    localparam int NVEC = 28;
    vec_t vec [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int r, input int i, input int w, input int x, input logic l);
        vec[r].valid[i]     = 1'b1;
        vec[r].last[i]      = l;
        vec[r].w[8*i +: 8]  = w[7:0];
        vec[r].x[8*i +: 8]  = x[7:0];
    endtask

    task automatic expo(input int r, input int id, input int sum);
        vec[r].exp_ov  = 1'b1;
        vec[r].exp_id  = id[1:0];
        vec[r].exp_sum = sum;
    endtask

    task automatic idle_inputs();
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        req_w     = 32'h0000_0000;
        req_x     = 32'h0000_0000;
    endtask

    initial begin
        int seen_ov;

        // ---------------- vector table ----------------
        for (int r = 0; r < NVEC; r++) vec[r] = '0;
        // req0 group: 3*4 + (-2)*5 + 7*(-1) = -5
        put(0, 0, 3, 4, 1'b0);
        put(1, 0, -2, 5, 1'b0);
        put(2, 0, 7, -1, 1'b1);
        for (int r = 0; r <= 2; r++) vec[r].exp_ready = 4'b0001;
        expo(8, 0, -5);
        for (int r = 0; r <= 7; r++) vec[r].exp_busy = 1'b1;
        // req1 single-element groups at signed extremes, back-to-back
        put(9, 1, -128, -128, 1'b1);
        put(10, 1, -128, 127, 1'b1);
        vec[9].exp_ready  = 4'b0010;
        vec[10].exp_ready = 4'b0010;
        expo(15, 1, 16384);
        expo(16, 1, -16256);
        for (int r = 9; r <= 15; r++) vec[r].exp_busy = 1'b1;
        // req0 (1*1,2*2) and req2 (10*10,-3*3) interleaved
        put(18, 0, 1, 1, 1'b0);
        put(18, 2, 10, 10, 1'b0);
        vec[18].exp_ready = 4'b0100;
        put(19, 0, 1, 1, 1'b0);
        put(19, 2, -3, 3, 1'b1);
        vec[19].exp_ready = 4'b0001;
        put(20, 2, -3, 3, 1'b1);
        vec[20].exp_ready = 4'b0100;
        put(21, 0, 2, 2, 1'b1);
        vec[21].exp_ready = 4'b0001;
        expo(26, 2, 91);
        expo(27, 0, 5);
        for (int r = 18; r <= 26; r++) vec[r].exp_busy = 1'b1;

        // ---------------- reset state ----------------
        rstn = 1'b0;
        idle_inputs();
        req_valid = 4'b1111;
        tick();
        tick();
        #1;
        chk("rst_ready_ptr", {28'd0, req_ready}, 32'h0000_0001);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_id", {30'd0, out_id}, 32'd0);
        chk("rst_out_sum", out_sum, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        idle_inputs();
        rstn = 1'b1;
        tick();

        // ---------------- table run ----------------
        for (int r = 0; r < NVEC; r++) begin
            req_valid = vec[r].valid;
            req_last  = vec[r].last;
            req_w     = vec[r].w;
            req_x     = vec[r].x;
            #1;
            chk($sformatf("ready[%0d]", r), {28'd0, req_ready}, {28'd0, vec[r].exp_ready});
            tick();
            chk($sformatf("out_valid[%0d]", r), {31'd0, out_valid}, {31'd0, vec[r].exp_ov});
            chk($sformatf("busy[%0d]", r), {31'd0, busy}, {31'd0, vec[r].exp_busy});
            if (vec[r].exp_ov) begin
                chk($sformatf("out_id[%0d]", r), {30'd0, out_id}, {30'd0, vec[r].exp_id});
                chk($sformatf("out_sum[%0d]", r), out_sum, vec[r].exp_sum);
            end
        end
        idle_inputs();

        // ---------------- round-robin fairness ----------------
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c < 8) begin
                req_valid = 4'b1111;
                req_last  = 4'b1111;
                req_w     = 32'h0403_0201;
                req_x     = 32'h0303_0303;
            end else begin
                idle_inputs();
            end
            #1;
            if (c < 8) chk($sformatf("rr_grant[%0d]", c), {28'd0, req_ready}, 32'd1 << (c % 4));
            else       chk($sformatf("rr_idle[%0d]", c), {28'd0, req_ready}, 32'd0);
            tick();
            if (c >= 6 && c < 14) begin
                chk($sformatf("rr_ov[%0d]", c), {31'd0, out_valid}, 32'd1);
                chk($sformatf("rr_id[%0d]", c), {30'd0, out_id}, (c - 6) % 4);
                chk($sformatf("rr_sum[%0d]", c), out_sum, 3 * (((c - 6) % 4) + 1));
            end else begin
                chk($sformatf("rr_ov[%0d]", c), {31'd0, out_valid}, 32'd0);
            end
        end

        // ---------------- reset mid-operation ----------------
        req_valid = 4'b0010;
        req_last  = 4'b0000;
        req_w     = 32'h0000_0500;
        req_x     = 32'h0000_0A00;
        #1;
        chk("mid_grant1", {28'd0, req_ready}, 32'h0000_0002);
        tick();
        idle_inputs();
        for (int c = 0; c < 7; c++) tick();
        chk("mid_acc_no_out", {31'd0, out_valid}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            req_valid = 4'b0010;
            req_last  = (c == 2) ? 4'b0010 : 4'b0000;
            req_w     = 32'h0000_0100;
            req_x     = 32'h0000_0100;
            tick();
        end
        idle_inputs();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_sum", out_sum, 32'd0);
        seen_ov = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid) seen_ov++;
        end
        chk("mid_no_ghost_out", seen_ov, 32'd0);
        req_valid = 4'b0010;
        req_last  = 4'b0010;
        req_w     = 32'h0000_0200;
        req_x     = 32'h0000_0200;
        #1;
        chk("fresh_grant1", {28'd0, req_ready}, 32'h0000_0002);
        tick();
        idle_inputs();
        for (int d = 1; d <= 6; d++) begin
            tick();
            if (d < 6) begin
                chk($sformatf("fresh_wait[%0d]", d), {31'd0, out_valid}, 32'd0);
            end else begin
                chk("fresh_ov", {31'd0, out_valid}, 32'd1);
                chk("fresh_id", {30'd0, out_id}, 32'd1);
                chk("fresh_sum", out_sum, 32'd4);
            end
        end

        // ---------------- idle ----------------
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("idle_ready[%0d]", c), {28'd0, req_ready}, 32'd0);
            tick();
            chk($sformatf("idle_busy[%0d]", c), {31'd0, busy}, 32'd0);
            chk($sformatf("idle_ov[%0d]", c), {31'd0, out_valid}, 32'd0);
        end
        // Pointer must still sit at requester 1 after the idle stretch.
        req_valid = 4'b1111;
        #1;
        chk("idle_ptr_held", {28'd0, req_ready}, 32'h0000_0004);
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
